// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: stall/flush/bubble,
// forwarding selects, and a data-memory wait FSM with watchdog. Optional HAZARD_PERF_CNT_EN adds perf counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_d1,
  input  logic [4:0]  rs_d2,
  input  logic        branch_d,
  input  logic [4:0]  rs_e1,
  input  logic [4:0]  rs_e2,
  input  logic [4:0]  rd_e,
  input  logic        load_e,
  input  logic        reg_write_e,
  input  logic        branch_result_e,
  input  logic        jump_e,
  input  logic [4:0]  rd_m,
  input  logic        reg_write_m,
  input  logic        load_m,
  input  logic        mem_req_m,
  input  logic        mem_ready,
  input  logic [4:0]  rd_w,
  input  logic        reg_write_w,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        bubble,
  output logic        stall_e,
  output logic        stall_m,
  output logic [1:0]  fwd_a_e,
  output logic [1:0]  fwd_b_e,
  output logic        mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_ld_stall,
  output logic [31:0] perf_mem_wait,
  output logic [31:0] perf_flush
`endif
);

  localparam int WDW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

  state_t         state_reg, state_next;
  logic [WDW-1:0] wdog_reg, wdog_next;
  logic           mem_err_reg;

  logic flush_rule, ld_use, br_stall, freeze_start;
  logic flush_act, ld_act;

  assign flush_rule   = branch_result_e | jump_e;
  assign ld_use       = load_e && (rd_e != 5'd0) && ((rd_e == rs_d1) || (rd_e == rs_d2));
  assign br_stall     = branch_d &&
                        ((reg_write_e && (rd_e != 5'd0) && ((rd_e == rs_d1) || (rd_e == rs_d2))) ||
                         (load_m && (rd_m != 5'd0) && ((rd_m == rs_d1) || (rd_m == rs_d2))));
  assign freeze_start = mem_req_m && !mem_ready;

  always_comb begin
    state_next = state_reg;
    wdog_next  = wdog_reg;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    bubble     = 1'b0;
    flush_act  = 1'b0;
    ld_act     = 1'b0;
    case (state_reg)
      RUN: begin
        if (freeze_start) begin
          // The freeze outranks the hazard rules: a taken branch stays frozen in E.
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          wdog_next  = WDW'(1);
          state_next = (MEM_TIMEOUT <= 1) ? MEM_ERR : MEM_WAIT;
        end else begin
          wdog_next = '0;
          if (flush_rule) begin
            flush_d   = 1'b1;
            bubble    = 1'b1;
            flush_act = 1'b1;
          end else if (ld_use || br_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            bubble  = 1'b1;
            ld_act  = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        if (mem_ready) begin
          state_next = RUN;
          wdog_next  = '0;
        end else if (wdog_reg >= WDW'(MEM_TIMEOUT - 1)) begin
          // wdog_reg counts the low cycles already seen; this one makes MEM_TIMEOUT.
          state_next = MEM_ERR;
          wdog_next  = '0;
        end else begin
          wdog_next = wdog_reg + WDW'(1);
        end
      end
      MEM_ERR: begin
        state_next = RUN;
        wdog_next  = '0;
      end
      default: begin
        state_next = RUN;
        wdog_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= RUN;
      wdog_reg    <= '0;
      mem_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wdog_reg    <= wdog_next;
      mem_err_reg <= (state_next == MEM_ERR);
    end
  end

  assign mem_err = mem_err_reg;

  // Forwarding, identical for both operands; M result wins over W.
  logic [4:0] rs_e [2];
  logic [1:0] fwd_sel [2];
  assign rs_e[0] = rs_e1;
  assign rs_e[1] = rs_e2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] =
        (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e[gi])) ? 2'b10 :
        (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e[gi])) ? 2'b01 : 2'b00;
    end
  endgenerate

  assign fwd_a_e = fwd_sel[0];
  assign fwd_b_e = fwd_sel[1];

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_ld_stall_reg, perf_mem_wait_reg, perf_flush_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ld_stall_reg <= '0;
      perf_mem_wait_reg <= '0;
      perf_flush_reg    <= '0;
    end else begin
      if (ld_act)                 perf_ld_stall_reg <= perf_ld_stall_reg + 32'd1;
      if (state_reg == MEM_WAIT)  perf_mem_wait_reg <= perf_mem_wait_reg + 32'd1;
      if (flush_act)              perf_flush_reg    <= perf_flush_reg + 32'd1;
    end
  end

  assign perf_ld_stall = perf_ld_stall_reg;
  assign perf_mem_wait = perf_mem_wait_reg;
  assign perf_flush    = perf_flush_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of combinational hazard/forward vectors plus
// hand-written memory-wait, watchdog, reset and perf-counter sequences.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs_d1, rs_d2, rs_e1, rs_e2, rd_e, rd_m, rd_w;
  logic branch_d, load_e, reg_write_e, branch_result_e, jump_e;
  logic reg_write_m, load_m, mem_req_m, mem_ready, reg_write_w;
  logic stall_f, stall_d, flush_d, bubble, stall_e, stall_m, mem_err;
  logic [1:0] fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_ld_stall, perf_mem_wait, perf_flush;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .rs_d1(rs_d1), .rs_d2(rs_d2), .branch_d(branch_d),
    .rs_e1(rs_e1), .rs_e2(rs_e2), .rd_e(rd_e),
    .load_e(load_e), .reg_write_e(reg_write_e),
    .branch_result_e(branch_result_e), .jump_e(jump_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .load_m(load_m),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .rd_w(rd_w), .reg_write_w(reg_write_w),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .bubble(bubble),
    .stall_e(stall_e), .stall_m(stall_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_ld_stall(perf_ld_stall), .perf_mem_wait(perf_mem_wait), .perf_flush(perf_flush)
`endif
  );

  typedef struct {
    logic [4:0] rs_d1, rs_d2; logic bd;
    logic [4:0] rs_e1, rs_e2, rd_e; logic ld_e, rw_e, br, jp;
    logic [4:0] rd_m; logic rw_m, ld_m;
    logic [4:0] rd_w; logic rw_w;
    logic st, fl, bu; logic [1:0] fa, fb;
  } vec_t;

  vec_t vec [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rs_d1 = 0; rs_d2 = 0; branch_d = 0; rs_e1 = 0; rs_e2 = 0; rd_e = 0;
    load_e = 0; reg_write_e = 0; branch_result_e = 0; jump_e = 0;
    rd_m = 0; reg_write_m = 0; load_m = 0; mem_req_m = 0; mem_ready = 0;
    rd_w = 0; reg_write_w = 0;
  endtask

  // Full control snapshot: {stall_f, stall_d, stall_e, stall_m, flush_d, bubble}
  task automatic chk_ctl(input string name, input logic [5:0] exp);
    chk(name, {26'd0, stall_f, stall_d, stall_e, stall_m, flush_d, bubble}, {26'd0, exp});
  endtask

  initial begin
    //            d1 d2 bd e1 e2 rde lde rwe br jp rdm rwm ldm rdw rww  st fl bu fa fb
    vec[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vec[1]  = '{5, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0};
    vec[2]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vec[3]  = '{3, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0};
    vec[4]  = '{5, 0, 0, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0};
    vec[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0};
    vec[6]  = '{6, 0, 1, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0};
    vec[7]  = '{0, 9, 1, 9, 0, 2, 0, 0, 0, 0, 9, 1, 1, 0, 0,  1, 0, 1, 2, 0};
    vec[8]  = '{6, 0, 0, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vec[9]  = '{4, 0, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1,  0, 0, 0, 0, 1};
    vec[10] = '{0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 7, 1, 0, 7, 1,  0, 0, 0, 2, 0};
    vec[11] = '{0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 1,  0, 0, 0, 1, 0};
    vec[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 1,  0, 0, 0, 0, 0};
    vec[13] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vec[14] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vec[15] = '{8, 0, 1, 0, 8, 0, 0, 0, 0, 0, 8, 1, 1, 8, 1,  1, 0, 1, 0, 2};

    clear_inputs();
    rst = 1'b1;
    #3;
    chk_ctl("reset_ctl", 6'b000000);
    chk("reset_fwd", {28'd0, fwd_a_e, fwd_b_e}, 32'd0);
    chk("reset_mem_err", {31'd0, mem_err}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Table-driven combinational rules in RUN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rs_d1 = vec[i].rs_d1; rs_d2 = vec[i].rs_d2; branch_d = vec[i].bd;
      rs_e1 = vec[i].rs_e1; rs_e2 = vec[i].rs_e2; rd_e = vec[i].rd_e;
      load_e = vec[i].ld_e; reg_write_e = vec[i].rw_e;
      branch_result_e = vec[i].br; jump_e = vec[i].jp;
      rd_m = vec[i].rd_m; reg_write_m = vec[i].rw_m; load_m = vec[i].ld_m;
      rd_w = vec[i].rd_w; reg_write_w = vec[i].rw_w;
      #1;
      chk($sformatf("vec%0d_ctl", i), {26'd0, stall_f, stall_d, stall_e, stall_m, flush_d, bubble},
          {26'd0, vec[i].st, vec[i].st, 1'b0, 1'b0, vec[i].fl, vec[i].bu});
      chk($sformatf("vec%0d_fwd", i), {28'd0, fwd_a_e, fwd_b_e}, {28'd0, vec[i].fa, vec[i].fb});
      $display("vec %0d: stall_f=%0b flush_d=%0b bubble=%0b fwd_a=%0b fwd_b=%0b",
               i, stall_f, flush_d, bubble, fwd_a_e, fwd_b_e);
    end

    // Load-use for one cycle, then the load leaves E
    @(negedge clk); clear_inputs(); load_e = 1; rd_e = 5; rs_d1 = 5; #1;
    chk_ctl("lu_cycle", 6'b110001);
    @(negedge clk); load_e = 0; #1;
    chk_ctl("lu_after", 6'b000000);

    // Memory wait: 3 low cycles then ready; taken branch waits frozen in E
    @(negedge clk); clear_inputs(); mem_req_m = 1; branch_result_e = 1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_ready = 1;
      #1;
      chk($sformatf("wait_freeze%0d", c), {26'd0, stall_f, stall_d, stall_e, stall_m, flush_d, bubble}, 32'b111100);
      chk($sformatf("wait_noerr%0d", c), {31'd0, mem_err}, 32'd0);
      $display("wait cycle %0d: stalls=%0b%0b%0b%0b", c, stall_f, stall_d, stall_e, stall_m);
      @(negedge clk);
    end
    mem_req_m = 0; mem_ready = 0; #1;
    chk_ctl("release_flush", 6'b000011);
    chk("release_noerr", {31'd0, mem_err}, 32'd0);

    // Zero-wait access: no stall, stays in RUN
    @(negedge clk); clear_inputs(); mem_req_m = 1; mem_ready = 1; #1;
    chk_ctl("zero_wait", 6'b000000);
    @(negedge clk); mem_req_m = 0; mem_ready = 0; #1;
    chk_ctl("zero_wait_next", 6'b000000);

    // Watchdog: MEM_TIMEOUT=4 low cycles frozen, then one-cycle mem_err with stalls released
    @(negedge clk); clear_inputs(); mem_req_m = 1; rs_e1 = 3; rd_m = 3; reg_write_m = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("wd_freeze%0d", c), {26'd0, stall_f, stall_d, stall_e, stall_m, flush_d, bubble}, 32'b111100);
      chk($sformatf("wd_noerr%0d", c), {31'd0, mem_err}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("wd_err_pulse", {31'd0, mem_err}, 32'd1);
    chk_ctl("wd_err_released", 6'b000000);
    chk("wd_fwd_any_state", {30'd0, fwd_a_e}, 32'd2);
    $display("watchdog expiry: mem_err=%0b stall_f=%0b", mem_err, stall_f);
    @(negedge clk); mem_req_m = 0; #1;
    chk("wd_err_one_cycle", {31'd0, mem_err}, 32'd0);
    chk_ctl("wd_back_run", 6'b000000);

    // Reset mid-wait: immediate RUN, no error pulse afterwards
    @(negedge clk); clear_inputs(); mem_req_m = 1;
    @(negedge clk); @(negedge clk);
    rst = 1; mem_req_m = 0; #1;
    chk_ctl("rst_midwait", 6'b000000);
    @(negedge clk); rst = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk($sformatf("rst_noerr%0d", c), {31'd0, mem_err}, 32'd0);
    end

`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk); clear_inputs(); rst = 1; #1;
    chk("perf_reset", perf_ld_stall | perf_mem_wait | perf_flush, 32'd0);
    @(negedge clk); rst = 0;
    load_e = 1; rd_e = 5; rs_d1 = 5;
    @(negedge clk); @(negedge clk); clear_inputs();
    mem_req_m = 1;
    @(negedge clk); @(negedge clk); @(negedge clk); mem_ready = 1;
    @(negedge clk); clear_inputs(); branch_result_e = 1;
    @(negedge clk); clear_inputs(); #1;
    chk("perf_ld_stall", perf_ld_stall, 32'd2);
    chk("perf_mem_wait", perf_mem_wait, 32'd3);
    chk("perf_flush", perf_flush, 32'd1);
    $display("perf: ld_stall=%0d mem_wait=%0d flush=%0d", perf_ld_stall, perf_mem_wait, perf_flush);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
